axi_stream_strip_header: RTL and testbench
==========================================

# axi_stream_strip_header

Downstream companion of the header-insertion stage. It accepts an AXI-Stream packet whose first bytes carry a header and removes the first `hdr_len` bytes of every packet. The removed header goes out on a separate handshaked side channel, in right-aligned insert format. The remaining payload is re-packed MSB-first, with a left-aligned keep on the last beat, and forwarded on the output stream.

## Interface
- `DATA_WD`, 32, stream data width in bits (multiple of 8).
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per beat (W below).
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  input beat valid.
- `data_in`  in  DATA_WD  input data; byte 0 (first) at `[DATA_WD-1 -: 8]`.
- `keep_in`  in  DATA_BYTE_WD  byte enables; MSB = byte 0; all ones except on the last beat; contiguous from MSB.
- `last_in`  in  1  last beat of packet.
- `ready_in`  out  1  input accept.
- `hdr_len`  in  `$clog2(DATA_BYTE_WD)+1`  header byte count, 1..W; sampled on the first beat.
- `valid_out`, `data_out`, `keep_out`, `last_out`  out  1/DATA_WD/DATA_BYTE_WD/1  payload stream; same byte conventions as the input.
- `ready_out`  in  1  payload accept.
- `valid_hdr`  out  1  header valid.
- `hdr_data`  out  DATA_WD  header bytes, right-aligned (last header byte at `[7:0]`); unused bytes are 0.
- `hdr_keep`  out  DATA_BYTE_WD  right-aligned ones, one per header byte (e.g. 0011 for 2 bytes).
- `ready_hdr`  in  1  header accept.
- `err_short`  out  1  one-cycle pulse: the packet ended before `hdr_len` bytes arrived.

## Operation
- Let N = the latched `hdr_len`. Values 0 or >W are clamped to W.
- Let R = W−N (residue bytes). Let k = popcount(`keep_in`) on the accepted beat.
- The input beat is accepted when `valid_in && ready_in`.
- The payload output register holds `valid_out` until `ready_out`.
- The header register holds `valid_hdr` until `ready_hdr`.
- IDLE (awaiting the first beat):
  - `ready_in` = (!`valid_hdr` || `ready_hdr`) && (!`valid_out` || `ready_out`).
  - On accept: latch N; `hdr_data` = bytes 0..N−1 right-aligned; `valid_hdr`=1.
  - Residue register ← bytes N..W−1, left-aligned.
  - If not `last_in` → BODY.
  - If `last_in` and k<N: header carries bytes 0..k−1, `hdr_keep` = k low ones, `err_short` pulses, no payload → IDLE.
  - If `last_in` and k=N: header only, no payload → IDLE.
  - If `last_in` and k>N: emit one payload beat with bytes N..k−1, `keep_out` = (k−N) MSB ones, `last_out`=1 → IDLE.
- BODY:
  - `ready_in` = !`valid_out` || `ready_out`.
  - Output beat = residue (R bytes) followed by the first N bytes of the input beat.
  - Not last: `keep_out` all ones; residue ← input bytes N..W−1.
  - Last with k≤N: `keep_out` = R+k MSB ones, `last_out`=1 → IDLE.
  - Last with k>N: full beat with `last_out`=0; residue ← bytes N..k−1 → FLUSH.
- FLUSH:
  - `ready_in`=0.
  - When the output register is free: emit residue, `keep_out` = (k−N) MSB ones, `last_out`=1 → IDLE.
- N=W gives R=0: payload beats pass through unchanged and FLUSH never occurs.
- All invalid output bytes are driven 0.
- The header may still be pending while payload flows. A new packet's first beat stalls until the previous header is taken.

## Timing
- Reset values: `valid_out`=0, `data_out`=0, `keep_out`=0, `last_out`=0, `valid_hdr`=0, `hdr_data`=0, `hdr_keep`=0, `err_short`=0, state IDLE. `ready_in`=1 after reset deasserts.
- Latency: the payload beat and the header are registered and appear the cycle after the input accept.
- Throughput: 1 beat/cycle in BODY with `ready_out` held high. One input bubble per FLUSH.
- `ready_in` is combinational from `ready_out`/`ready_hdr` and the state; there is no comb path from `valid_in` to `ready_in`.
- Simultaneous consume and refill of the output register in the same cycle keeps `valid_out`=1 with no bubble.
- Reset asserted mid-packet: all registers clear immediately. The rest of the interrupted packet is treated as a new packet.

## Test plan
- W=4, `hdr_len`=2, 10-byte packet 01..0A (beats 01020304, 05060708, 090A0000/keep 1100 last) → header 00000102 keep 0011; payload 03040506/1111, then 0708090A/1111 with `last_out`=1.
- `hdr_len`=1, 6 bytes 01..06 (beats 01020304, 05060000/1100 last) → header 00000001/0001; payload 02030405/1111 `last_out`=0, then 06000000/1000 `last_out`=1; `ready_in` low for one cycle during FLUSH.
- `hdr_len`=4, single-beat packet AABBCCDD last → header AABBCCDD/1111; no payload beat. Repeat with keep 1100 → header 0000AABB/0011 and an `err_short` pulse.
- Random `ready_out`/`ready_hdr` backpressure over 100 packets with random `hdr_len` → payload and header streams match a reference model byte-for-byte. Outputs stay stable while `valid` && !`ready`.
- `ready_hdr` held low → the second packet's first beat is not accepted until the header handshake completes.
- Reset asserted in BODY → all outputs 0 on the next edge; a following packet is processed correctly.

Source files
------------

// File: rtl/axi_stream_strip_header_if.sv
// Bundles the input stream, payload stream and header side channel of the header stripper.
// master = traffic source/sink side, slave = the stripping stage itself.
interface axi_stream_strip_header_if #(
    parameter int DATA_WD = 32
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int LEN_WD       = $clog2(DATA_BYTE_WD) + 1;

    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic [LEN_WD-1:0]       hdr_len;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    logic                    valid_hdr;
    logic [DATA_WD-1:0]      hdr_data;
    logic [DATA_BYTE_WD-1:0] hdr_keep;
    logic                    ready_hdr;
    logic                    err_short;

    modport master (
        output valid_in, data_in, keep_in, last_in, hdr_len, ready_out, ready_hdr,
        input  ready_in, valid_out, data_out, keep_out, last_out,
               valid_hdr, hdr_data, hdr_keep, err_short
    );

    modport slave (
        input  valid_in, data_in, keep_in, last_in, hdr_len, ready_out, ready_hdr,
        output ready_in, valid_out, data_out, keep_out, last_out,
               valid_hdr, hdr_data, hdr_keep, err_short
    );
endinterface

// File: rtl/axi_stream_strip_header.sv
// Strips the first hdr_len bytes of each packet onto a right-aligned header channel and
// re-packs the remaining payload MSB-first; 1-cycle latency, output/header held until accepted.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axi_stream_strip_header_if.slave   bus
);
    localparam int W  = DATA_BYTE_WD;
    localparam int LW = $clog2(W) + 1;
    localparam int SW = $clog2(DATA_WD) + 1;
    localparam logic [LW-1:0] W_L = LW'(W);

    typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

    state_t             state;
    logic [LW-1:0]      n_q;
    logic [DATA_WD-1:0] res_dat;
    logic [W-1:0]       res_keep;

    logic [DATA_WD-1:0] in_dat;
    logic [LW-1:0]      k_in;
    logic [LW-1:0]      n_in;
    logic [LW-1:0]      n_cur;
    logic [LW-1:0]      r_cur;
    logic [LW-1:0]      hc;
    logic [SW-1:0]      sh_n;
    logic [SW-1:0]      sh_r;
    logic [SW-1:0]      sh_hc;
    logic [DATA_WD-1:0] data_tail;
    logic [DATA_WD-1:0] data_head;
    logic [DATA_WD-1:0] hdr_dat;
    logic [W-1:0]       keep_tail;
    logic [W-1:0]       keep_head;
    logic [W-1:0]       hdr_k;
    logic               tail_any;
    logic               out_free;
    logic               hdr_free;
    logic               rdy;
    logic               accept;

    always_comb begin
        in_dat = '0;
        k_in   = '0;
        // Bytes outside keep are zeroed so every shifted view below carries clean padding.
        for (int i = 0; i < W; i++) begin
            in_dat[8*i +: 8] = bus.data_in[8*i +: 8] & {8{bus.keep_in[i]}};
            k_in = k_in + LW'(bus.keep_in[i]);
        end
    end

    always_comb begin
        n_in      = (bus.hdr_len == '0 || bus.hdr_len > W_L) ? W_L : bus.hdr_len;
        n_cur     = (state == IDLE) ? n_in : n_q;
        r_cur     = W_L - n_cur;
        hc        = (k_in < n_cur) ? k_in : n_cur;
        sh_n      = {n_cur, 3'b000};
        sh_r      = {r_cur, 3'b000};
        sh_hc     = {W_L - hc, 3'b000};
        data_tail = in_dat << sh_n;
        data_head = in_dat >> sh_r;
        hdr_dat   = in_dat >> sh_hc;
        keep_tail = bus.keep_in << n_cur;
        keep_head = bus.keep_in >> r_cur;
        hdr_k     = ~({W{1'b1}} << hc);
        tail_any  = (keep_tail != '0);
    end

    always_comb begin
        out_free = !bus.valid_out || bus.ready_out;
        hdr_free = !bus.valid_hdr || bus.ready_hdr;
        rdy      = 1'b0;
        case (state)
            IDLE:    rdy = out_free && hdr_free;
            BODY:    rdy = out_free;
            default: rdy = 1'b0;
        endcase
        accept = bus.valid_in && rdy;
    end

    assign bus.ready_in = rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            n_q           <= '0;
            res_dat       <= '0;
            res_keep      <= '0;
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
            bus.keep_out  <= '0;
            bus.last_out  <= 1'b0;
            bus.valid_hdr <= 1'b0;
            bus.hdr_data  <= '0;
            bus.hdr_keep  <= '0;
            bus.err_short <= 1'b0;
        end else begin
            bus.err_short <= 1'b0;
            if (bus.valid_out && bus.ready_out) begin
                bus.valid_out <= 1'b0;
                bus.data_out  <= '0;
                bus.keep_out  <= '0;
                bus.last_out  <= 1'b0;
            end
            if (bus.valid_hdr && bus.ready_hdr) begin
                bus.valid_hdr <= 1'b0;
                bus.hdr_data  <= '0;
                bus.hdr_keep  <= '0;
            end
            case (state)
                IDLE: if (accept) begin
                    n_q           <= n_cur;
                    bus.valid_hdr <= 1'b1;
                    bus.hdr_data  <= hdr_dat;
                    bus.hdr_keep  <= hdr_k;
                    res_dat       <= data_tail;
                    res_keep      <= keep_tail;
                    if (!bus.last_in) begin
                        state <= BODY;
                    end else if (k_in < n_cur) begin
                        bus.err_short <= 1'b1;
                    end else if (k_in > n_cur) begin
                        bus.valid_out <= 1'b1;
                        bus.data_out  <= data_tail;
                        bus.keep_out  <= keep_tail;
                        bus.last_out  <= 1'b1;
                    end
                end
                BODY: if (accept) begin
                    // Residue fills the MSB side, the head of the new beat completes it.
                    bus.valid_out <= 1'b1;
                    bus.data_out  <= res_dat | data_head;
                    bus.keep_out  <= res_keep | keep_head;
                    bus.last_out  <= bus.last_in && !tail_any;
                    res_dat       <= data_tail;
                    res_keep      <= keep_tail;
                    if (bus.last_in) begin
                        state <= tail_any ? FLUSH : IDLE;
                    end
                end
                FLUSH: if (out_free) begin
                    bus.valid_out <= 1'b1;
                    bus.data_out  <= res_dat;
                    bus.keep_out  <= res_keep;
                    bus.last_out  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: directed test-plan packets plus random backpressure.
`timescale 1ns/1ps
module tb_axi_stream_strip_header;
    localparam int DW = 32;
    localparam int W  = DW / 8;
    localparam int LW = $clog2(W) + 1;

    typedef struct packed { logic [DW-1:0] d; logic [W-1:0] k; logic l; } pay_t;
    typedef struct packed { logic [DW-1:0] d; logic [W-1:0] k; } hdr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_stream_strip_header_if #(.DATA_WD(DW)) bus ();
    axi_stream_strip_header #(.DATA_WD(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0;
    int   passes = 0;
    int   exp_err = 0;
    int   err_seen = 0;
    int   stall_cnt = 0;
    bit   bp_mode = 1'b0;
    bit   ro_fix = 1'b1;
    bit   rh_fix = 1'b1;
    pay_t pay_q[$];
    hdr_t hdr_q[$];

    always @(negedge clk) begin
        if (bp_mode) begin
            bus.ready_out = ($urandom_range(0, 99) < 60);
            bus.ready_hdr = ($urandom_range(0, 99) < 50);
        end else begin
            bus.ready_out = ro_fix;
            bus.ready_hdr = rh_fix;
        end
    end

    logic po_hold = 1'b0;
    logic ph_hold = 1'b0;
    pay_t po_snap, pe, pg;
    hdr_t ph_snap, he, hg;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            po_hold = 1'b0;
            ph_hold = 1'b0;
        end else begin
            pg.d = bus.data_out; pg.k = bus.keep_out; pg.l = bus.last_out;
            hg.d = bus.hdr_data; hg.k = bus.hdr_keep;
            if (po_hold) begin
                checks++;
                if (bus.valid_out !== 1'b1 || pg !== po_snap)
                    $display("FAIL payload_stable got v=%b d=%h k=%b l=%b expected v=1 d=%h k=%b l=%b",
                             bus.valid_out, pg.d, pg.k, pg.l, po_snap.d, po_snap.k, po_snap.l);
                else passes++;
            end
            if (ph_hold) begin
                checks++;
                if (bus.valid_hdr !== 1'b1 || hg !== ph_snap)
                    $display("FAIL header_stable got v=%b d=%h k=%b expected v=1 d=%h k=%b",
                             bus.valid_hdr, hg.d, hg.k, ph_snap.d, ph_snap.k);
                else passes++;
            end
            po_hold = 1'b0;
            ph_hold = 1'b0;
            if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
                checks++;
                if (pay_q.size() == 0) begin
                    $display("FAIL payload_extra got d=%h k=%b l=%b expected no beat", pg.d, pg.k, pg.l);
                end else begin
                    pe = pay_q.pop_front();
                    if (pg !== pe)
                        $display("FAIL payload_beat got d=%h k=%b l=%b expected d=%h k=%b l=%b",
                                 pg.d, pg.k, pg.l, pe.d, pe.k, pe.l);
                    else passes++;
                end
            end else if (bus.valid_out === 1'b1) begin
                po_hold = 1'b1;
                po_snap = pg;
            end
            if (bus.valid_hdr === 1'b1 && bus.ready_hdr === 1'b1) begin
                checks++;
                if (hdr_q.size() == 0) begin
                    $display("FAIL header_extra got d=%h k=%b expected no header", hg.d, hg.k);
                end else begin
                    he = hdr_q.pop_front();
                    if (hg !== he)
                        $display("FAIL header_word got d=%h k=%b expected d=%h k=%b", hg.d, hg.k, he.d, he.k);
                    else passes++;
                end
            end else if (bus.valid_hdr === 1'b1) begin
                ph_hold = 1'b1;
                ph_snap = hg;
            end
            if (bus.err_short === 1'b1) err_seen++;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l,
                             input logic [LW-1:0] hl);
        logic acc;
        int   t;
        @(negedge clk); #1;
        bus.valid_in = 1'b1; bus.data_in = d; bus.keep_in = k; bus.last_in = l; bus.hdr_len = hl;
        acc = 1'b0;
        t = 0;
        while (!acc) begin
            #2;
            acc = bus.ready_in;
            if (!acc) stall_cnt++;
            @(posedge clk); #1;
            if (!acc) begin
                t++;
                if (t > 500) begin
                    checks++;
                    $display("FAIL beat_accept_timeout ready_in=0 for %0d cycles, expected 1", t);
                    bus.valid_in = 1'b0;
                    return;
                end
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic send_packet(input logic [7:0] b[$], input logic [LW-1:0] hl, input bit garbage);
        int n;
        n = b.size();
        for (int j = 0; j < n; j += W) begin
            logic [DW-1:0] d;
            logic [W-1:0]  k;
            d = '0;
            k = '0;
            for (int i = 0; i < W; i++) begin
                if (j + i < n) begin
                    d[DW-1-8*i -: 8] = b[j+i];
                    k[W-1-i] = 1'b1;
                end else if (garbage) begin
                    d[DW-1-8*i -: 8] = 8'($urandom);
                end
            end
            send_beat(d, k, (j + W >= n), hl);
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic model(input logic [7:0] b[$], input int hl);
        int   n, len, hc, plen;
        hdr_t h;
        pay_t p;
        n   = (hl == 0 || hl > W) ? W : hl;
        len = b.size();
        hc  = (len < n) ? len : n;
        h.d = '0;
        h.k = '0;
        for (int i = 0; i < hc; i++) begin
            h.d = {h.d[DW-9:0], b[i]};
            h.k = {h.k[W-2:0], 1'b1};
        end
        hdr_q.push_back(h);
        if (len < n) exp_err++;
        plen = len - hc;
        for (int j = 0; j < plen; j += W) begin
            p.d = '0;
            p.k = '0;
            p.l = (j + W >= plen);
            for (int i = 0; i < W; i++) begin
                if (j + i < plen) begin
                    p.d[DW-1-8*i -: 8] = b[hc+j+i];
                    p.k[W-1-i] = 1'b1;
                end
            end
            pay_q.push_back(p);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((pay_q.size() != 0 || hdr_q.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
    endtask

    function automatic pay_t mk_pay(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
        pay_t p;
        p.d = d; p.k = k; p.l = l;
        return p;
    endfunction

    function automatic hdr_t mk_hdr(input logic [DW-1:0] d, input logic [W-1:0] k);
        hdr_t h;
        h.d = d; h.k = k;
        return h;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out} !== '0)
            $display("FAIL reset_payload got v=%b d=%h k=%b l=%b expected all 0",
                     bus.valid_out, bus.data_out, bus.keep_out, bus.last_out);
        else passes++;
        checks++;
        if ({bus.valid_hdr, bus.hdr_data, bus.hdr_keep, bus.err_short} !== '0)
            $display("FAIL reset_header got v=%b d=%h k=%b e=%b expected all 0",
                     bus.valid_hdr, bus.hdr_data, bus.hdr_keep, bus.err_short);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        checks++;
        if (bus.ready_in !== 1'b1) $display("FAIL reset_ready_in got %b expected 1", bus.ready_in);
        else passes++;
    endtask

    task automatic test_hdr2_repack();
        logic [7:0] b[$];
        for (int i = 1; i <= 10; i++) b.push_back(8'(i));
        hdr_q.push_back(mk_hdr(32'h0000_0102, 4'b0011));
        pay_q.push_back(mk_pay(32'h0304_0506, 4'b1111, 1'b0));
        pay_q.push_back(mk_pay(32'h0708_090A, 4'b1111, 1'b1));
        send_packet(b, 3'd2, 1'b0);
        wait_drain();
        checks++;
        if (pay_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL hdr2_drain got pay=%0d hdr=%0d pending expected 0", pay_q.size(), hdr_q.size());
        else passes++;
    endtask

    task automatic test_flush();
        logic [7:0] b[$];
        for (int i = 1; i <= 6; i++) b.push_back(8'(i));
        hdr_q.push_back(mk_hdr(32'h0000_0001, 4'b0001));
        pay_q.push_back(mk_pay(32'h0203_0405, 4'b1111, 1'b0));
        pay_q.push_back(mk_pay(32'h0600_0000, 4'b1000, 1'b1));
        send_packet(b, 3'd1, 1'b0);
        #2;
        checks++;
        if (bus.ready_in !== 1'b0) $display("FAIL flush_ready_low got %b expected 0", bus.ready_in);
        else passes++;
        @(posedge clk); #3;
        checks++;
        if (bus.ready_in !== 1'b1) $display("FAIL flush_ready_back got %b expected 1", bus.ready_in);
        else passes++;
        wait_drain();
        checks++;
        if (pay_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL flush_drain got pay=%0d hdr=%0d pending expected 0", pay_q.size(), hdr_q.size());
        else passes++;
    endtask

    task automatic test_full_header();
        logic [7:0] b[$];
        int e0;
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        hdr_q.push_back(mk_hdr(32'hAABB_CCDD, 4'b1111));
        send_packet(b, 3'd4, 1'b0);
        wait_drain();
        checks++;
        if (hdr_q.size() != 0) $display("FAIL full_hdr_drain got %0d pending expected 0", hdr_q.size());
        else passes++;
        e0 = err_seen;
        b = '{8'hAA, 8'hBB};
        hdr_q.push_back(mk_hdr(32'h0000_AABB, 4'b0011));
        exp_err++;
        send_packet(b, 3'd4, 1'b0);
        wait_drain();
        checks++;
        if (hdr_q.size() != 0) $display("FAIL short_hdr_drain got %0d pending expected 0", hdr_q.size());
        else passes++;
        checks++;
        if (err_seen - e0 != 1) $display("FAIL err_short_pulse got %0d cycles expected 1", err_seen - e0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        for (int p = 0; p < 2; p++) begin
            b.delete();
            for (int i = 0; i < 14; i++) b.push_back(8'(8'h10 + 8'(p * 16) + 8'(i)));
            model(b, 2);
        end
        stall_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            b.delete();
            for (int i = 0; i < 14; i++) b.push_back(8'(8'h10 + 8'(p * 16) + 8'(i)));
            send_packet(b, 3'd2, 1'b0);
        end
        checks++;
        if (stall_cnt != 0) $display("FAIL b2b_throughput got %0d stall cycles expected 0", stall_cnt);
        else passes++;
        wait_drain();
        checks++;
        if (pay_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL b2b_drain got pay=%0d hdr=%0d pending expected 0", pay_q.size(), hdr_q.size());
        else passes++;
    endtask

    task automatic test_hdr_stall();
        logic [7:0] b1[$];
        logic [7:0] b2[$];
        rh_fix = 1'b0;
        @(posedge clk);
        b1 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        b2 = '{8'h31, 8'h32, 8'h33};
        model(b1, 2);
        model(b2, 2);
        send_packet(b1, 3'd2, 1'b0);
        @(negedge clk); #1;
        bus.valid_in = 1'b1; bus.data_in = 32'h3132_3300; bus.keep_in = 4'b1110;
        bus.last_in = 1'b1; bus.hdr_len = 3'd2;
        for (int c = 0; c < 6; c++) begin
            #2;
            checks++;
            if (bus.ready_in !== 1'b0) $display("FAIL hdr_stall_ready cycle %0d got %b expected 0", c, bus.ready_in);
            else passes++;
            @(negedge clk); #1;
        end
        bus.valid_in = 1'b0;
        rh_fix = 1'b1;
        send_packet(b2, 3'd2, 1'b0);
        wait_drain();
        checks++;
        if (pay_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL hdr_stall_drain got pay=%0d hdr=%0d pending expected 0", pay_q.size(), hdr_q.size());
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        int len, hl;
        bp_mode = 1'b1;
        for (int p = 0; p < 100; p++) begin
            b.delete();
            len = $urandom_range(1, 14);
            hl  = $urandom_range(0, 7);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            model(b, hl);
            send_packet(b, LW'(hl), 1'b1);
        end
        wait_drain();
        bp_mode = 1'b0;
        checks++;
        if (pay_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL random_drain got pay=%0d hdr=%0d pending expected 0", pay_q.size(), hdr_q.size());
        else passes++;
        checks++;
        if (err_seen != exp_err) $display("FAIL random_err_count got %0d expected %0d", err_seen, exp_err);
        else passes++;
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] b[$];
        ro_fix = 1'b0;
        rh_fix = 1'b0;
        @(posedge clk);
        send_beat(32'h0102_0304, 4'b1111, 1'b0, 3'd2);
        send_beat(32'h0506_0708, 4'b1111, 1'b0, 3'd2);
        bus.valid_in = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b1) $display("FAIL mid_pkt_loaded got %b expected 1", bus.valid_out);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out,
             bus.valid_hdr, bus.hdr_data, bus.hdr_keep, bus.err_short} !== '0)
            $display("FAIL mid_pkt_reset got vo=%b d=%h k=%b vh=%b hd=%h expected all 0",
                     bus.valid_out, bus.data_out, bus.keep_out, bus.valid_hdr, bus.hdr_data);
        else passes++;
        ro_fix = 1'b1;
        rh_fix = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hdr_q.push_back(mk_hdr(32'h0000_090A, 4'b0011));
        send_beat(32'h090A_0000, 4'b1100, 1'b1, 3'd2);
        bus.valid_in = 1'b0;
        b = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
        model(b, 3);
        send_packet(b, 3'd3, 1'b0);
        wait_drain();
        checks++;
        if (pay_q.size() != 0 || hdr_q.size() != 0)
            $display("FAIL post_reset_drain got pay=%0d hdr=%0d pending expected 0", pay_q.size(), hdr_q.size());
        else passes++;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.keep_in  = '0;
        bus.last_in  = 1'b0;
        bus.hdr_len  = '0;
        test_reset();
        test_hdr2_repack();
        test_flush();
        test_full_header();
        test_back_to_back();
        test_hdr_stall();
        test_random();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish, %0d/%0d passed so far", passes, checks);
        $fatal(1);
    end
endmodule
